// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO serial configuration loader.
// Holds the chain geometry, the loader FSM state type and the bit positions
// of the housekeeping bit-bang register (reg 0x13).
package gpio_cfg_pkg;

    // Configuration bits carried by each GPIO control block.
    localparam int unsigned CTRL_BITS      = 13;
    // GPIO control blocks on each of the two serial chains.
    localparam int unsigned PADS_PER_CHAIN = 19;

    // Counter widths derived from the chain geometry.
    localparam int unsigned IDX_W = $clog2(PADS_PER_CHAIN);
    localparam int unsigned BIT_W = $clog2(CTRL_BITS);

    // Bit positions inside housekeeping reg 0x13.
    localparam int unsigned BB_EN     = 1;
    localparam int unsigned BB_RESETN = 2;
    localparam int unsigned BB_LOAD   = 3;
    localparam int unsigned BB_CLOCK  = 4;
    localparam int unsigned BB_DATA1  = 5;
    localparam int unsigned BB_DATA2  = 6;

    typedef logic [CTRL_BITS-1:0] cfg_word_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSetup,
        StHigh,
        StLoad,
        StFinish
    } xfer_state_e;

endpackage

// File: rtl/gpio_serial_clkgen.sv
// Half-period tick generator for the serial chain clock.
// Counts wb_clk cycles while enabled and pulses tick_o on the last cycle of
// each HALF_PERIOD-long window, then wraps. Disabling or restarting clears the
// count so the next enabled window is always a full half-period.
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   en_i       count enable (FSM is in a timed state)
//   restart_i  synchronous clear, overrides en_i
//   tick_o     high on the final cycle of a half-period window
module gpio_serial_clkgen #(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    // Keep at least one bit so HALF_PERIOD=1 still elaborates.
    localparam int unsigned CntW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(HALF_PERIOD - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (restart_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_serial_loader.sv
// Serial transfer engine for the two GPIO control shift chains.
// Walks the pad index from the far end of the chains down to 0, fetching one
// config word per chain per pad and shifting it out MSB first, then strobes
// serial_load so every control block latches its word. A bit-bang override
// passes the housekeeping reg 0x13 lines straight to the chain (registered)
// and aborts any transfer in flight.
//
// Ports:
//   wb_clk_i, wb_rstn_i    system clock, asynchronous active-low reset
//   xfer_start             pulse: begin an automatic transfer
//   bitbang_en, bb_*       bit-bang select and raw chain line values
//   cfg_idx                pad index being fetched
//   cfg_data_1/2           config words for cfg_idx (valid one cycle later)
//   serial_*               chain clock, load, resetn and data lines
//   xfer_busy, xfer_done   transfer in progress, completion pulse
module gpio_serial_loader
    import gpio_cfg_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rstn_i,
    input  logic                 xfer_start,
    input  logic                 bitbang_en,
    input  logic                 bb_resetn,
    input  logic                 bb_load,
    input  logic                 bb_clock,
    input  logic                 bb_data_1,
    input  logic                 bb_data_2,
    output logic [IDX_W-1:0]     cfg_idx,
    input  logic [CTRL_BITS-1:0] cfg_data_1,
    input  logic [CTRL_BITS-1:0] cfg_data_2,
    output logic                 serial_clock,
    output logic                 serial_load,
    output logic                 serial_resetn,
    output logic                 serial_data_1,
    output logic                 serial_data_2,
    output logic                 xfer_busy,
    output logic                 xfer_done
);

    localparam logic [IDX_W-1:0] PadLast = IDX_W'(PADS_PER_CHAIN - 1);
    localparam logic [BIT_W-1:0] BitLast = BIT_W'(CTRL_BITS - 1);

    xfer_state_e      state_q, state_d;
    logic [IDX_W-1:0] pad_q, pad_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    cfg_word_t        sr1_q, sr1_d;
    cfg_word_t        sr2_q, sr2_d;
    // Second FETCH cycle: cfg_data now reflects cfg_idx.
    logic             fetch_ph_q, fetch_ph_d;

    logic [IDX_W-1:0] cfg_idx_q, cfg_idx_d;
    logic             sclk_q, sclk_d;
    logic             sload_q, sload_d;
    logic             srstn_q, srstn_d;
    logic             sdata1_q, sdata1_d;
    logic             sdata2_q, sdata2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tick;
    logic             timed_state;

    assign timed_state = (state_q == StSetup) || (state_q == StHigh) || (state_q == StLoad);

    gpio_serial_clkgen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_clkgen (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rstn_i),
        .en_i      (timed_state),
        .restart_i (bitbang_en),
        .tick_o    (tick)
    );

    always_comb begin
        state_d    = state_q;
        pad_d      = pad_q;
        bit_d      = bit_q;
        sr1_d      = sr1_q;
        sr2_d      = sr2_q;
        fetch_ph_d = fetch_ph_q;
        cfg_idx_d  = cfg_idx_q;
        sclk_d     = sclk_q;
        sload_d    = sload_q;
        srstn_d    = srstn_q;
        sdata1_d   = sdata1_q;
        sdata2_d   = sdata2_q;
        busy_d     = busy_q;
        done_d     = done_q;

        if (bitbang_en) begin
            // Bit-bang wins over everything, including a same-cycle xfer_start.
            state_d    = StIdle;
            fetch_ph_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            sclk_d     = bb_clock;
            sload_d    = bb_load;
            srstn_d    = bb_resetn;
            sdata1_d   = bb_data_1;
            sdata2_d   = bb_data_2;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sclk_d   = 1'b0;
                    sload_d  = 1'b0;
                    srstn_d  = 1'b1;
                    sdata1_d = 1'b0;
                    sdata2_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b0;
                    if (xfer_start) begin
                        // Far end of the chain goes first so pad 0 ends up last.
                        state_d    = StFetch;
                        pad_d      = PadLast;
                        cfg_idx_d  = PadLast;
                        fetch_ph_d = 1'b0;
                        busy_d     = 1'b1;
                    end
                end

                StFetch: begin
                    if (!fetch_ph_q) begin
                        fetch_ph_d = 1'b1;
                    end else begin
                        fetch_ph_d = 1'b0;
                        sr1_d      = cfg_data_1;
                        sr2_d      = cfg_data_2;
                        bit_d      = BitLast;
                        sclk_d     = 1'b0;
                        sdata1_d   = cfg_data_1[CTRL_BITS-1];
                        sdata2_d   = cfg_data_2[CTRL_BITS-1];
                        state_d    = StSetup;
                    end
                end

                StSetup: begin
                    if (tick) begin
                        sclk_d  = 1'b1;
                        state_d = StHigh;
                    end
                end

                StHigh: begin
                    if (tick) begin
                        sclk_d = 1'b0;
                        sr1_d  = {sr1_q[CTRL_BITS-2:0], 1'b0};
                        sr2_d  = {sr2_q[CTRL_BITS-2:0], 1'b0};
                        if (bit_q != '0) begin
                            bit_d    = bit_q - 1'b1;
                            sdata1_d = sr1_q[CTRL_BITS-2];
                            sdata2_d = sr2_q[CTRL_BITS-2];
                            state_d  = StSetup;
                        end else if (pad_q != '0) begin
                            pad_d     = pad_q - 1'b1;
                            cfg_idx_d = pad_q - 1'b1;
                            state_d   = StFetch;
                        end else begin
                            sdata1_d = 1'b0;
                            sdata2_d = 1'b0;
                            sload_d  = 1'b1;
                            state_d  = StLoad;
                        end
                    end
                end

                StLoad: begin
                    if (tick) begin
                        sload_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end
                end

                StFinish: begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q    <= StIdle;
            pad_q      <= '0;
            bit_q      <= '0;
            sr1_q      <= '0;
            sr2_q      <= '0;
            fetch_ph_q <= 1'b0;
            cfg_idx_q  <= '0;
            sclk_q     <= 1'b0;
            sload_q    <= 1'b0;
            srstn_q    <= 1'b0;
            sdata1_q   <= 1'b0;
            sdata2_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pad_q      <= pad_d;
            bit_q      <= bit_d;
            sr1_q      <= sr1_d;
            sr2_q      <= sr2_d;
            fetch_ph_q <= fetch_ph_d;
            cfg_idx_q  <= cfg_idx_d;
            sclk_q     <= sclk_d;
            sload_q    <= sload_d;
            srstn_q    <= srstn_d;
            sdata1_q   <= sdata1_d;
            sdata2_q   <= sdata2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cfg_idx       = cfg_idx_q;
    assign serial_clock  = sclk_q;
    assign serial_load   = sload_q;
    assign serial_resetn = srstn_q;
    assign serial_data_1 = sdata1_q;
    assign serial_data_2 = sdata2_q;
    assign xfer_busy     = busy_q;
    assign xfer_done     = done_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader: table-driven bit-bang vectors plus
// hand-written transfer, abort, ignored-start and reset-in-LOAD sequences.
module tb_gpio_serial_loader;
    import gpio_cfg_pkg::*;

    localparam int unsigned HP      = 4;
    localparam int unsigned NBITS   = CTRL_BITS * PADS_PER_CHAIN;
    // Busy spans every FETCH (2 cycles) and bit (2*HP) of every pad, plus LOAD.
    localparam int unsigned BUSY_CYC = PADS_PER_CHAIN * (2 + 2 * HP * CTRL_BITS) + HP;

    logic                 wb_clk_i = 1'b0;
    logic                 wb_rstn_i = 1'b0;
    logic                 xfer_start = 1'b0;
    logic                 bitbang_en = 1'b0;
    logic                 bb_resetn = 1'b0;
    logic                 bb_load = 1'b0;
    logic                 bb_clock = 1'b0;
    logic                 bb_data_1 = 1'b0;
    logic                 bb_data_2 = 1'b0;
    logic [IDX_W-1:0]     cfg_idx;
    logic [CTRL_BITS-1:0] cfg_data_1 = '0;
    logic [CTRL_BITS-1:0] cfg_data_2 = '0;
    logic                 serial_clock, serial_load, serial_resetn;
    logic                 serial_data_1, serial_data_2;
    logic                 xfer_busy, xfer_done;

    gpio_serial_loader #(
        .HALF_PERIOD (HP)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rstn_i     (wb_rstn_i),
        .xfer_start    (xfer_start),
        .bitbang_en    (bitbang_en),
        .bb_resetn     (bb_resetn),
        .bb_load       (bb_load),
        .bb_clock      (bb_clock),
        .bb_data_1     (bb_data_1),
        .bb_data_2     (bb_data_2),
        .cfg_idx       (cfg_idx),
        .cfg_data_1    (cfg_data_1),
        .cfg_data_2    (cfg_data_2),
        .serial_clock  (serial_clock),
        .serial_load   (serial_load),
        .serial_resetn (serial_resetn),
        .serial_data_1 (serial_data_1),
        .serial_data_2 (serial_data_2),
        .xfer_busy     (xfer_busy),
        .xfer_done     (xfer_done)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic pat   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [CTRL_BITS-1:0] word1(input logic [IDX_W-1:0] i);
        if (pat) return 13'h1803 ^ (13'(i) * 13'h0137);
        return 13'h1803;
    endfunction

    function automatic logic [CTRL_BITS-1:0] word2(input logic [IDX_W-1:0] i);
        if (pat) return 13'h0403 ^ (13'(i) * 13'h0291);
        return 13'h0403;
    endfunction

    // Config register file model: data follows cfg_idx with one cycle latency.
    initial forever begin
        @(posedge wb_clk_i);
        cyc++;
        cfg_data_1 <= word1(cfg_idx);
        cfg_data_2 <= word2(cfg_idx);
    end

    // Chain-side monitor, sampled on the falling edge.
    int   edges, bad_gap, last_edge, load_cyc, load_pulses, first_load, load_last;
    int   done_cnt, done_cyc, busy_cyc, overlap;
    logic prev_clk, prev_load;
    logic s1 [NBITS];
    logic s2 [NBITS];

    task automatic clear_mon();
        edges = 0; bad_gap = 0; last_edge = 0; load_cyc = 0; load_pulses = 0;
        first_load = 0; load_last = 0; done_cnt = 0; done_cyc = 0; busy_cyc = 0;
        overlap = 0;
    endtask

    initial begin
        clear_mon();
        prev_clk  = 1'b0;
        prev_load = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (serial_clock && !prev_clk) begin
                if (edges > 0) begin
                    // First bit of a new pad pays for the 2-cycle fetch.
                    if ((cyc - last_edge) != ((edges % CTRL_BITS == 0) ? 2 * HP + 2 : 2 * HP))
                        bad_gap++;
                end
                if (edges < NBITS) begin
                    s1[edges] = serial_data_1;
                    s2[edges] = serial_data_2;
                end
                last_edge = cyc;
                edges++;
            end
            if (serial_load) begin
                load_cyc++;
                load_last = cyc;
                if (!prev_load) begin
                    load_pulses++;
                    first_load = cyc;
                end
                if (serial_clock) overlap++;
            end
            if (xfer_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (xfer_busy) busy_cyc++;
            prev_clk  = serial_clock;
            prev_load = serial_load;
        end
    end

    function automatic logic [4:0] lines();
        return {serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2};
    endfunction

    task automatic pulse_start();
        @(negedge wb_clk_i);
        xfer_start = 1'b1;
        @(negedge wb_clk_i);
        xfer_start = 1'b0;
    endtask

    // Full transfer with end-to-end checks; optional extra xfer_start mid-way.
    task automatic run_xfer(input string tag, input int restart_after);
        int   t;
        int   bad1, bad2;
        logic [CTRL_BITS-1:0] w1, w2, first13;
        int   p, b;
        clear_mon();
        pulse_start();
        chk({tag, "_busy_rise"}, 32'(xfer_busy), 32'd1);
        chk({tag, "_first_idx"}, 32'(cfg_idx), 32'(PADS_PER_CHAIN - 1));
        t = 0;
        while (!xfer_done && t < 3000) begin
            @(negedge wb_clk_i);
            t++;
            if (t == restart_after) xfer_start = 1'b1;
            else                    xfer_start = 1'b0;
        end
        xfer_start = 1'b0;
        chk({tag, "_done_timeout"}, 32'(xfer_done), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(xfer_busy), 32'd0);
        repeat (20) @(negedge wb_clk_i);
        chk({tag, "_edges"}, 32'(edges), 32'(NBITS));
        chk({tag, "_gaps"}, 32'(bad_gap), 32'd0);
        chk({tag, "_load_pulses"}, 32'(load_pulses), 32'd1);
        chk({tag, "_load_width"}, 32'(load_cyc), 32'(HP));
        chk({tag, "_load_after_fall"}, 32'(first_load), 32'(last_edge + HP));
        chk({tag, "_load_clk_overlap"}, 32'(overlap), 32'd0);
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_after_load"}, 32'(done_cyc), 32'(load_last + 1));
        chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(BUSY_CYC));
        chk({tag, "_idle_busy"}, 32'(xfer_busy), 32'd0);
        bad1 = 0;
        bad2 = 0;
        for (int k = 0; k < int'(NBITS); k++) begin
            p  = PADS_PER_CHAIN - 1 - k / CTRL_BITS;
            b  = CTRL_BITS - 1 - k % CTRL_BITS;
            w1 = word1(IDX_W'(p));
            w2 = word2(IDX_W'(p));
            if (s1[k] !== w1[b]) bad1++;
            if (s2[k] !== w2[b]) bad2++;
        end
        chk({tag, "_stream1"}, 32'(bad1), 32'd0);
        chk({tag, "_stream2"}, 32'(bad2), 32'd0);
        if (!pat) begin
            for (int k = 0; k < int'(CTRL_BITS); k++) first13[CTRL_BITS - 1 - k] = s1[k];
            chk({tag, "_first13"}, 32'(first13), 32'h1803);
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] reg13;
        logic       start;
        logic [4:0] exp;   // {clock, load, resetn, data_1, data_2}
    } bb_vec_t;

    bb_vec_t    vecs [6];
    logic [4:0] prev_exp;
    int         t;

    initial begin
        vecs[0] = '{"bb_clk_lo",  8'h26, 1'b0, 5'b00110};
        vecs[1] = '{"bb_clk_hi",  8'h36, 1'b1, 5'b10110};
        vecs[2] = '{"bb_clk_lo2", 8'h26, 1'b0, 5'b00110};
        vecs[3] = '{"bb_load",    8'h4a, 1'b0, 5'b01001};
        vecs[4] = '{"bb_all",     8'h7e, 1'b0, 5'b11111};
        vecs[5] = '{"bb_off",     8'h7c, 1'b0, 5'b00100};

        // Reset values, then first cycle after reset release.
        repeat (3) @(negedge wb_clk_i);
        chk("rst_lines", 32'(lines()), 32'd0);
        chk("rst_busy_done", 32'({xfer_busy, xfer_done}), 32'd0);
        chk("rst_idx", 32'(cfg_idx), 32'd0);
        wb_rstn_i = 1'b1;
        @(negedge wb_clk_i);
        chk("post_rst_lines", 32'(lines()), 32'b00100);

        // Bit-bang vectors: registered pass-through, FSM stays idle.
        prev_exp = 5'b00100;
        foreach (vecs[i]) begin
            @(negedge wb_clk_i);
            bitbang_en = vecs[i].reg13[BB_EN];
            bb_resetn  = vecs[i].reg13[BB_RESETN];
            bb_load    = vecs[i].reg13[BB_LOAD];
            bb_clock   = vecs[i].reg13[BB_CLOCK];
            bb_data_1  = vecs[i].reg13[BB_DATA1];
            bb_data_2  = vecs[i].reg13[BB_DATA2];
            xfer_start = vecs[i].start;
            #1;
            chk({vecs[i].name, "_latency"}, 32'(lines()), 32'(prev_exp));
            @(negedge wb_clk_i);
            xfer_start = 1'b0;
            chk(vecs[i].name, 32'(lines()), 32'(vecs[i].exp));
            chk({vecs[i].name, "_busy"}, 32'(xfer_busy), 32'd0);
            prev_exp = vecs[i].exp;
        end
        bb_resetn = 1'b0; bb_load = 1'b0; bb_clock = 1'b0; bb_data_1 = 1'b0; bb_data_2 = 1'b0;
        repeat (3) @(negedge wb_clk_i);

        // Normal transfer with constant words.
        pat = 1'b0;
        run_xfer("xfer", 0);

        // Second xfer_start mid-transfer is ignored.
        run_xfer("restart_ignored", 500);

        // xfer_start together with bitbang_en rising: no transfer.
        clear_mon();
        @(negedge wb_clk_i);
        xfer_start = 1'b1;
        bitbang_en = 1'b1;
        @(negedge wb_clk_i);
        xfer_start = 1'b0;
        chk("start_with_bb_busy", 32'(xfer_busy), 32'd0);
        bitbang_en = 1'b0;
        repeat (30) @(negedge wb_clk_i);
        chk("start_with_bb_idle", 32'({xfer_busy, xfer_done}), 32'd0);
        chk("start_with_bb_edges", 32'(edges), 32'd0);

        // Abort after 100 clock edges via bit-bang.
        clear_mon();
        pulse_start();
        t = 0;
        while (edges < 100 && t < 3000) begin
            @(negedge wb_clk_i);
            #1;
            t++;
        end
        chk("abort_reach_100", 32'(edges >= 100), 32'd1);
        bitbang_en = 1'b1;
        bb_resetn  = 1'b1;
        @(negedge wb_clk_i);
        chk("abort_busy_drop", 32'(xfer_busy), 32'd0);
        repeat (40) @(negedge wb_clk_i);
        chk("abort_no_load", 32'(load_pulses), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        bitbang_en = 1'b0;
        bb_resetn  = 1'b0;
        @(negedge wb_clk_i);
        chk("bb_fall_auto", 32'(lines()), 32'b00100);

        // Fresh transfer after abort, index-dependent words.
        pat = 1'b1;
        run_xfer("after_abort", 0);
        pat = 1'b0;

        // Asynchronous reset during LOAD.
        clear_mon();
        pulse_start();
        t = 0;
        while (!serial_load && t < 3000) begin
            @(negedge wb_clk_i);
            t++;
        end
        chk("rst_load_reached", 32'(serial_load), 32'd1);
        #2;
        wb_rstn_i = 1'b0;
        #1;
        chk("rst_load_lines", 32'(lines()), 32'd0);
        chk("rst_load_busy_done", 32'({xfer_busy, xfer_done}), 32'd0);
        chk("rst_load_idx", 32'(cfg_idx), 32'd0);
        repeat (3) @(negedge wb_clk_i);
        chk("rst_load_held", 32'(lines()), 32'd0);
        wb_rstn_i = 1'b1;
        @(negedge wb_clk_i);
        chk("rst_load_release", 32'(lines()), 32'b00100);
        repeat (10) @(negedge wb_clk_i);
        chk("rst_load_no_done", 32'(done_cnt), 32'd0);
        chk("rst_load_idle", 32'(xfer_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
